// File: rtl/rx_ts_queue_pkg.sv
// rx_ts_queue_pkg
//   Shared constants and types for the receive-timestamp queue.
//   Record layout (MSB to LSB, 184 bits):
//     {timestamp[79:0], sourcePortIdentity[79:0], seqId[15:0],
//      messageType[3:0], majorSdoId[3:0]}
//   The capture FSM state type and a record packing helper also live here.
package rx_ts_queue_pkg;

   localparam int TS_W    = 80;
   localparam int SPI_W   = 80;
   localparam int SEQ_W   = 16;
   localparam int TYPE_W  = 4;
   localparam int SDO_W   = 4;
   localparam int REC_W   = TS_W + SPI_W + SEQ_W + TYPE_W + SDO_W;

   localparam int SDO_LSB  = 0;
   localparam int TYPE_LSB = SDO_LSB  + SDO_W;
   localparam int SEQ_LSB  = TYPE_LSB + TYPE_W;
   localparam int SPI_LSB  = SEQ_LSB  + SEQ_W;
   localparam int TS_LSB   = SPI_LSB  + SPI_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } cap_state_e;

   function automatic logic [REC_W-1:0] pack_record(
      input logic [TS_W-1:0]   ts,
      input logic [SPI_W-1:0]  spi,
      input logic [SEQ_W-1:0]  seq,
      input logic [TYPE_W-1:0] msg_type,
      input logic [SDO_W-1:0]  sdo
   );
      return {ts, spi, seq, msg_type, sdo};
   endfunction

endpackage

// File: rtl/rx_ts_ram.sv
// rx_ts_ram
//   DEPTH x W register array with one write port and a combinational
//   (show-ahead) read port.
//   Ports:
//     clk_i    - clock
//     we_i     - write enable
//     waddr_i  - write address
//     wdata_i  - write data
//     raddr_i  - read address
//     rdata_o  - read data, combinational from the array
module rx_ts_ram
   import rx_ts_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int W     = REC_W
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Contents are not reset; the queue masks the read data while empty.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
         if (we_i && (waddr_i == AW'(gi))) begin
            mem_q[gi] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_ts_queue.sv
// rx_ts_queue
//   Receive-timestamp queue. Latches the RTC time on each rx SFD trigger,
//   pairs it with the parsed PTP header fields on the matching valid pulse
//   and pushes the record into a small FIFO read and popped by the CPU.
//   Optional build macro: RXTS_TIMEOUT_EN -- when defined, a pending capture
//   is abandoned after TIMEOUT cycles without a valid.
//   Ports:
//     rtc_clk / rtc_rst_n       - clock, synchronous active-low reset
//     rtc_time_i                - RTC time (48 s + 32 ns)
//     rxts_en_i, clear_i        - queue enable, flush pulse
//     rxts_trig_i, rxts_valid_i - SFD trigger, PTP header valid
//     rx_*_i                    - parsed header fields
//     pop_i                     - CPU pop pulse
//     head_o                    - show-ahead head record (0 while empty)
//     count_o, empty_o, full_o  - FIFO occupancy
//     overflow_o, drop_cnt_o    - sticky overflow, saturating drop count
//     int_rxts_o                - level interrupt while records are pending
module rx_ts_queue
   import rx_ts_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic              rtc_clk,
   input  logic              rtc_rst_n,
   input  logic [TS_W-1:0]   rtc_time_i,
   input  logic              rxts_en_i,
   input  logic              clear_i,
   input  logic              rxts_trig_i,
   input  logic              rxts_valid_i,
   input  logic [SPI_W-1:0]  rx_sourcePortIdentity_i,
   input  logic [SEQ_W-1:0]  rx_seqId_i,
   input  logic [TYPE_W-1:0] rx_messageType_i,
   input  logic [SDO_W-1:0]  rx_majorSdoId_i,
   input  logic              pop_i,
   output logic [REC_W-1:0]  head_o,
   output logic [AW:0]       count_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              overflow_o,
   output logic [7:0]        drop_cnt_o,
   output logic              int_rxts_o
);

   cap_state_e      state_q;
   logic [TS_W-1:0] held_ts_q;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic            overflow_q;
   logic [7:0]      drop_cnt_q;

   logic            empty, full;
   logic            pop_eff, push_req, push_ok, push_drop;
   logic [REC_W-1:0] wr_rec, rd_rec;

`ifdef RXTS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt_q;
`else
   // TIMEOUT only matters when the pending-capture watchdog is built in.
   localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign pop_eff  = pop_i && !empty;
   assign push_req = rxts_en_i && (state_q == ST_PEND) && rxts_valid_i;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push_ok   = push_req && (!full || pop_eff);
   assign push_drop = push_req && full && !pop_eff;

   // Fields come from the valid cycle; time comes from the earlier trigger.
   assign wr_rec = pack_record(held_ts_q, rx_sourcePortIdentity_i, rx_seqId_i,
                               rx_messageType_i, rx_majorSdoId_i);

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   rx_ts_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (REC_W)
   ) u_ram (
      .clk_i   (rtc_clk),
      .we_i    (push_ok && rtc_rst_n && !clear_i),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_rec),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_rec)
   );

   // FIFO pointers and flags. Pointers wrap naturally since DEPTH = 2**AW.
   always_ff @(posedge rtc_clk) begin
      if (!rtc_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (clear_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push_drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   // Capture FSM. A trigger always (re)latches the time; in PEND a
   // coincident valid pushes the previously held time first.
   always_ff @(posedge rtc_clk) begin
      if (!rtc_rst_n) begin
         state_q   <= ST_IDLE;
         held_ts_q <= '0;
`ifdef RXTS_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else if (clear_i || !rxts_en_i) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rxts_trig_i) begin
                  held_ts_q <= rtc_time_i;
                  state_q   <= ST_PEND;
`ifdef RXTS_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end
            end
            ST_PEND: begin
               if (rxts_trig_i) begin
                  held_ts_q <= rtc_time_i;
`ifdef RXTS_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end else if (rxts_valid_i) begin
                  state_q <= ST_IDLE;
               end
`ifdef RXTS_TIMEOUT_EN
               // Counter equals the number of PEND cycles already elapsed.
               else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign head_o     = empty ? '0 : rd_rec;
   assign count_o    = count_q;
   assign empty_o    = empty;
   assign full_o     = full;
   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;
   assign int_rxts_o = !empty;

endmodule

// File: tb/tb_rx_ts_queue.sv
module tb_rx_ts_queue;

   logic          rtc_clk = 1'b0;
   logic          rtc_rst_n;
   logic [79:0]   rtc_time_i;
   logic          rxts_en_i, clear_i, rxts_trig_i, rxts_valid_i, pop_i;
   logic [79:0]   rx_sourcePortIdentity_i;
   logic [15:0]   rx_seqId_i;
   logic [3:0]    rx_messageType_i;
   logic [3:0]    rx_majorSdoId_i;
   logic [183:0]  head_o;
   logic [2:0]    count_o;
   logic          empty_o, full_o, overflow_o, int_rxts_o;
   logic [7:0]    drop_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 rtc_clk = ~rtc_clk;

   rx_ts_queue #(.DEPTH(4), .AW(2), .TIMEOUT(16)) dut (
      .rtc_clk                 (rtc_clk),
      .rtc_rst_n               (rtc_rst_n),
      .rtc_time_i              (rtc_time_i),
      .rxts_en_i               (rxts_en_i),
      .clear_i                 (clear_i),
      .rxts_trig_i             (rxts_trig_i),
      .rxts_valid_i            (rxts_valid_i),
      .rx_sourcePortIdentity_i (rx_sourcePortIdentity_i),
      .rx_seqId_i              (rx_seqId_i),
      .rx_messageType_i        (rx_messageType_i),
      .rx_majorSdoId_i         (rx_majorSdoId_i),
      .pop_i                   (pop_i),
      .head_o                  (head_o),
      .count_o                 (count_o),
      .empty_o                 (empty_o),
      .full_o                  (full_o),
      .overflow_o              (overflow_o),
      .drop_cnt_o              (drop_cnt_o),
      .int_rxts_o              (int_rxts_o)
   );

   // Expected record built from the bench's own field constants.
   function automatic logic [183:0] rec(input logic [79:0] ts, input logic [15:0] seq);
      return {ts, rx_sourcePortIdentity_i, seq, rx_messageType_i, rx_majorSdoId_i};
   endfunction

   task automatic tick();
      @(posedge rtc_clk);
      #1;
   endtask

   task automatic push_rec(input logic [79:0] ts, input logic [15:0] seq);
      rtc_time_i = ts; rxts_trig_i = 1'b1; tick(); rxts_trig_i = 1'b0;
      rx_seqId_i = seq; rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1; tick(); clear_i = 1'b0;
   endtask

   task automatic test_reset();
      rtc_rst_n = 1'b0; tick(); tick(); rtc_rst_n = 1'b1;
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
      n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
      n_vec++; if (full_o !== 1'b0 || overflow_o !== 1'b0 || int_rxts_o !== 1'b0) begin n_err++; $display("FAIL reset_flags got full=%b ovf=%b int=%b want 0 0 0", full_o, overflow_o, int_rxts_o); end
      n_vec++; if (drop_cnt_o !== 8'd0 || head_o !== 184'd0) begin n_err++; $display("FAIL reset_drop_head got drop=%0d head=%h want 0 0", drop_cnt_o, head_o); end
      pop_i = 1'b1; tick(); pop_i = 1'b0;
      n_vec++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL pop_empty got count=%0d empty=%b want 0 1", count_o, empty_o); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [79:0] ts;
      ts = 80'h0000_0000_0001_0000_0064;
      rx_messageType_i = 4'h0;
      rtc_time_i = ts; rxts_trig_i = 1'b1; tick(); rxts_trig_i = 1'b0;
      rtc_time_i = 80'hFFFF; tick(); tick();
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL basic_pend_count got %0d want 0", count_o); end
      rx_seqId_i = 16'h0011; rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL basic_count got %0d want 1", count_o); end
      n_vec++; if (head_o[183:104] !== ts || head_o[23:8] !== 16'h0011) begin n_err++; $display("FAIL basic_ts_seq got ts=%h seq=%h want %h 0011", head_o[183:104], head_o[23:8], ts); end
      n_vec++; if (head_o !== rec(ts, 16'h0011)) begin n_err++; $display("FAIL basic_head got %h want %h", head_o, rec(ts, 16'h0011)); end
      n_vec++; if (int_rxts_o !== 1'b1 || empty_o !== 1'b0) begin n_err++; $display("FAIL basic_int got int=%b empty=%b want 1 0", int_rxts_o, empty_o); end
      pop_i = 1'b1; tick(); pop_i = 1'b0;
      n_vec++; if (empty_o !== 1'b1 || int_rxts_o !== 1'b0) begin n_err++; $display("FAIL basic_pop got empty=%b int=%b want 1 0", empty_o, int_rxts_o); end
      rx_messageType_i = 4'h3;
      $display("test_basic done");
   endtask

   task automatic test_overwrite();
      rtc_time_i = 80'd100; rxts_trig_i = 1'b1; tick();
      rtc_time_i = 80'd200; tick(); rxts_trig_i = 1'b0;
      rx_seqId_i = 16'h0022; rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL overwrite_count got %0d want 1", count_o); end
      n_vec++; if (head_o !== rec(80'd200, 16'h0022)) begin n_err++; $display("FAIL overwrite_head got %h want %h", head_o, rec(80'd200, 16'h0022)); end
      do_clear();
      $display("test_overwrite done");
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) push_rec(80'(i), 16'(i));
      n_vec++; if (count_o !== 3'd4 || full_o !== 1'b1) begin n_err++; $display("FAIL ovf_count got count=%0d full=%b want 4 1", count_o, full_o); end
      n_vec++; if (overflow_o !== 1'b1 || drop_cnt_o !== 8'd1) begin n_err++; $display("FAIL ovf_flags got ovf=%b drop=%0d want 1 1", overflow_o, drop_cnt_o); end
      n_vec++; if (head_o !== rec(80'd1, 16'd1)) begin n_err++; $display("FAIL ovf_head got %h want %h", head_o, rec(80'd1, 16'd1)); end
      // Push and pop together while full.
      rtc_time_i = 80'd6; rxts_trig_i = 1'b1; tick(); rxts_trig_i = 1'b0;
      rx_seqId_i = 16'd6; rxts_valid_i = 1'b1; pop_i = 1'b1; tick();
      rxts_valid_i = 1'b0; pop_i = 1'b0;
      n_vec++; if (count_o !== 3'd4 || drop_cnt_o !== 8'd1) begin n_err++; $display("FAIL full_pushpop got count=%0d drop=%0d want 4 1", count_o, drop_cnt_o); end
      n_vec++; if (head_o !== rec(80'd2, 16'd2)) begin n_err++; $display("FAIL full_pushpop_head got %h want %h", head_o, rec(80'd2, 16'd2)); end
      // Drain to check the record written through the full slot.
      pop_i = 1'b1; tick(); tick(); tick(); pop_i = 1'b0;
      n_vec++; if (head_o !== rec(80'd6, 16'd6) || count_o !== 3'd1) begin n_err++; $display("FAIL wrap_head got %h count=%0d want %h 1", head_o, count_o, rec(80'd6, 16'd6)); end
      push_rec(80'd7, 16'd7);
      do_clear();
      n_vec++; if (count_o !== 3'd0 || overflow_o !== 1'b0 || drop_cnt_o !== 8'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL clear got count=%0d ovf=%b drop=%0d empty=%b want 0 0 0 1", count_o, overflow_o, drop_cnt_o, empty_o); end
      $display("test_overflow done");
   endtask

   task automatic test_back_to_back();
      rtc_time_i = 80'd10; rxts_trig_i = 1'b1; tick();
      rtc_time_i = 80'd20; rx_seqId_i = 16'd7; rxts_valid_i = 1'b1; tick();
      rxts_trig_i = 1'b0;
      n_vec++; if (count_o !== 3'd1 || head_o !== rec(80'd10, 16'd7)) begin n_err++; $display("FAIL b2b_first got count=%0d head=%h want 1 %h", count_o, head_o, rec(80'd10, 16'd7)); end
      rx_seqId_i = 16'd8; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL b2b_second_count got %0d want 2", count_o); end
      pop_i = 1'b1; tick(); pop_i = 1'b0;
      n_vec++; if (head_o !== rec(80'd20, 16'd8)) begin n_err++; $display("FAIL b2b_second_head got %h want %h", head_o, rec(80'd20, 16'd8)); end
      do_clear();
      // Trigger and valid together in IDLE: latch only, valid orphaned.
      rtc_time_i = 80'd30; rxts_trig_i = 1'b1; rxts_valid_i = 1'b1; tick();
      rxts_trig_i = 1'b0; rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL idle_simul_count got %0d want 0", count_o); end
      rx_seqId_i = 16'd9; rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd1 || head_o !== rec(80'd30, 16'd9)) begin n_err++; $display("FAIL idle_simul_push got count=%0d head=%h want 1 %h", count_o, head_o, rec(80'd30, 16'd9)); end
      rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL idle_valid got %0d want 1", count_o); end
      do_clear();
      $display("test_back_to_back done");
   endtask

   task automatic test_enable();
      push_rec(80'd33, 16'd33);
      rxts_en_i = 1'b0;
      push_rec(80'd34, 16'd34);
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL en_suppress got %0d want 1", count_o); end
      rxts_en_i = 1'b1;
      rtc_time_i = 80'd35; rxts_trig_i = 1'b1; tick(); rxts_trig_i = 1'b0;
      rxts_en_i = 1'b0; tick(); rxts_en_i = 1'b1;
      rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd1 || head_o !== rec(80'd33, 16'd33)) begin n_err++; $display("FAIL en_force_idle got count=%0d head=%h want 1 %h", count_o, head_o, rec(80'd33, 16'd33)); end
      rxts_en_i = 1'b0; pop_i = 1'b1; tick(); pop_i = 1'b0; rxts_en_i = 1'b1;
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL en_pop got %0d want 0", count_o); end
      $display("test_enable done");
   endtask

   task automatic test_timeout();
      rtc_time_i = 80'd40; rxts_trig_i = 1'b1; tick(); rxts_trig_i = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      rx_seqId_i = 16'd40; rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
`ifdef RXTS_TIMEOUT_EN
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL timeout_nopush got %0d want 0", count_o); end
`else
      n_vec++; if (count_o !== 3'd1 || head_o !== rec(80'd40, 16'd40)) begin n_err++; $display("FAIL late_valid got count=%0d head=%h want 1 %h", count_o, head_o, rec(80'd40, 16'd40)); end
`endif
      do_clear();
      $display("test_timeout done");
   endtask

   task automatic test_reset_midpend();
      push_rec(80'd41, 16'd41);
      push_rec(80'd42, 16'd42);
      rtc_time_i = 80'd50; rxts_trig_i = 1'b1; tick(); rxts_trig_i = 1'b0;
      n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL midpend_pre got %0d want 2", count_o); end
      rtc_rst_n = 1'b0; tick(); rtc_rst_n = 1'b1;
      n_vec++; if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || int_rxts_o !== 1'b0) begin n_err++; $display("FAIL midpend_rst got count=%0d empty=%b full=%b int=%b want 0 1 0 0", count_o, empty_o, full_o, int_rxts_o); end
      n_vec++; if (head_o !== 184'd0 || overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL midpend_rst_head got head=%h ovf=%b drop=%0d want 0 0 0", head_o, overflow_o, drop_cnt_o); end
      rxts_valid_i = 1'b1; tick(); rxts_valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL midpend_valid got %0d want 0", count_o); end
      $display("test_reset_midpend done");
   endtask

   initial begin
      rtc_rst_n = 1'b0; rtc_time_i = '0; rxts_en_i = 1'b1; clear_i = 1'b0;
      rxts_trig_i = 1'b0; rxts_valid_i = 1'b0; pop_i = 1'b0;
      rx_sourcePortIdentity_i = 80'hA1B2_C3D4_E5F6_0718_293A;
      rx_seqId_i = '0; rx_messageType_i = 4'h3; rx_majorSdoId_i = 4'h5;
      test_reset();
      test_basic();
      test_overwrite();
      test_overflow();
      test_back_to_back();
      test_enable();
      test_timeout();
      test_reset_midpend();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
